// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage: issues imem requests, queues {pc, instr} for decode, handles flush
module if_fetch_unit #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [XLEN-1:0]          pc_i,
    output logic                     pc_en_o,
    input  logic                     flush_i,
    output logic                     imem_req_o,
    output logic [XLEN-1:0]          imem_addr_o,
    input  logic                     imem_rvalid_i,
    input  logic [XLEN-1:0]          imem_rdata_i,
    output logic                     id_valid_o,
    input  logic                     id_ready_i,
    output logic [XLEN-1:0]          id_pc_o,
    output logic [XLEN-1:0]          id_instr_o,
    output logic [$clog2(DEPTH):0]   fifo_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DROP
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q;
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [XLEN-1:0]   req_pc_q;
    logic [XLEN-1:0]   fifo_pc_q    [DEPTH];
    logic [XLEN-1:0]   fifo_instr_q [DEPTH];

    logic              issue;
    logic              push;
    logic              pop;
    logic [CW:0]       occ_after_push;

    assign pop            = (count_q != '0) & id_ready_i;
    // Occupancy once the current response lands and any pop retires; decides back-to-back issue.
    assign occ_after_push = {1'b0, count_q} + (CW+1)'(1) - (CW+1)'(pop);

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        push    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!flush_i && (count_q < CW'(DEPTH))) begin
                    issue   = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid_i) begin
                    if (flush_i) begin
                        state_d = S_IDLE;
                    end else begin
                        push = 1'b1;
                        if (occ_after_push < (CW+1)'(DEPTH)) begin
                            issue = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end else if (flush_i) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_rvalid_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Keep the request quiet while reset is held, even though IDLE would otherwise issue.
        if (!rst_n) begin
            issue = 1'b0;
        end
    end

    assign imem_req_o  = issue;
    assign pc_en_o     = issue;
    assign imem_addr_o = pc_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            req_pc_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc_q[i]    <= '0;
                fifo_instr_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (issue) begin
                req_pc_q <= pc_i;
            end
            if (flush_i) begin
                count_q  <= '0;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) begin
                    fifo_pc_q[wr_ptr_q]    <= req_pc_q;
                    fifo_instr_q[wr_ptr_q] <= imem_rdata_i;
                    wr_ptr_q               <= wr_ptr_q + AW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                end
                count_q <= count_q + CW'(push) - CW'(pop);
            end
        end
    end

`ifndef SYNTHESIS
    // Issue reserves a slot, so a response can never land on a full queue.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(push && (count_q == CW'(DEPTH))));
        end
    end
`endif

    assign id_valid_o = (count_q != '0);
    assign id_pc_o    = fifo_pc_q[rd_ptr_q];
    assign id_instr_o = fifo_instr_q[rd_ptr_q];
    assign fifo_cnt_o = count_q;

endmodule
